// File: rtl/note_pkg.sv
// Shared constants and FSM state type for the falling-note lane game.
package note_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int SPRITE_H   = 32;
    localparam int WIN_LO_DEF = 428;
    localparam int WIN_HI_DEF = 470;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FALL = 1'b1
    } state_e;

endpackage

// File: rtl/pattern_fifo.sv
// Small flop-based FIFO holding queued note patterns; pushes while full are dropped.
module pattern_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // simultaneous push and pop leaves occupancy unchanged
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/note_lanes.sv
// Falling-note rhythm core: pattern queue, fall timing, key judgement,
// score/combo tracking and per-pixel lane sprite decode.
module note_lanes #(
    parameter int LANES      = 4,
    parameter int TICK_DIV   = 200000,
    parameter int FIFO_DEPTH = 4,
    parameter int WIN_LO     = note_pkg::WIN_LO_DEF,
    parameter int WIN_HI     = note_pkg::WIN_HI_DEF,
    parameter int SCREEN_H   = note_pkg::SCREEN_H,
    parameter int SPRITE_H   = note_pkg::SPRITE_H
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    input  logic [LANES-1:0] KEY,
    input  logic [LANES-1:0] pattern_in,
    input  logic             pattern_valid,
    output logic             pattern_ready,
    input  logic [9:0]       next_x,
    input  logic [9:0]       next_y,
    output logic [LANES-1:0] sprite_pattern,
    output logic [9:0]       y_pos,
    output logic             hit,
    output logic             miss,
    output logic             note_done,
    output logic [15:0]      score,
    output logic [7:0]       combo
);
    import note_pkg::*;

    localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LANE_W = SCREEN_W / LANES;
    localparam logic [9:0] Y_EXIT = 10'(SCREEN_H);
    localparam logic [9:0] Y_WLO  = 10'(WIN_LO);
    localparam logic [9:0] Y_WHI  = 10'(WIN_HI);
    localparam logic [9:0] HALF_H = 10'(SPRITE_H / 2);

    state_e           state_q, state_d;
    logic [9:0]       y_q, y_d;
    logic [LANES-1:0] cur_q, cur_d;
    logic             judged_q, judged_d;
    logic             jhit_q, jhit_d;
    logic [15:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             hit_q, hit_d, miss_q, miss_d, done_q, done_d;
    logic [LANES-1:0] ks1_q, ks2_q, kprev_q;

    logic [LANES-1:0]              fifo_dout;
    logic                          fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          tick, press_edge, judge, in_window;
    logic [LANES-1:0]              pressed;

    pattern_fifo #(
        .WIDTH (LANES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_25),
        .rst_n (reset),
        .push  (pattern_valid),
        .din   (pattern_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, fifo_count};

    assign pattern_ready = !fifo_full;
    assign fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;
    assign tick          = (tcnt_q == TW'(TICK_DIV - 1));
    assign pressed       = ks2_q;
    assign press_edge    = |(pressed & ~kprev_q);
    assign in_window     = (y_q >= Y_WLO) && (y_q <= Y_WHI);
    assign judge         = (state_q == ST_FALL) && press_edge && !judged_q
                           && (cur_q != '0) && in_window;

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        cur_d    = cur_q;
        judged_d = judged_q;
        jhit_d   = jhit_q;
        score_d  = score_q;
        combo_d  = combo_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        done_d   = 1'b0;
        tcnt_d   = tick ? '0 : tcnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    cur_d    = fifo_dout;
                    y_d      = '0;
                    judged_d = 1'b0;
                    jhit_d   = 1'b0;
                    state_d  = ST_FALL;
                end
            end
            ST_FALL: begin
                if (judge) begin
                    judged_d = 1'b1;
                    if (pressed == cur_q) begin
                        jhit_d  = 1'b1;
                        hit_d   = 1'b1;
                        score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                        combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
                    end else begin
                        miss_d  = 1'b1;
                        combo_d = '0;
                    end
                end
                if (tick) begin
                    if (y_q == Y_EXIT) begin
                        y_d     = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        // unjudged real note scrolled off: counts as a miss
                        if (!judged_q && (cur_q != '0)) begin
                            miss_d  = 1'b1;
                            combo_d = '0;
                        end
                    end else begin
                        y_d = y_q + 10'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            y_q      <= '0;
            cur_q    <= '0;
            judged_q <= 1'b0;
            jhit_q   <= 1'b0;
            score_q  <= '0;
            combo_q  <= '0;
            tcnt_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            done_q   <= 1'b0;
            ks1_q    <= '0;
            ks2_q    <= '0;
            kprev_q  <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            cur_q    <= cur_d;
            judged_q <= judged_d;
            jhit_q   <= jhit_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            tcnt_q   <= tcnt_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            done_q   <= done_d;
            // keys are stored already inverted so a cleared synchronizer means released
            ks1_q    <= ~KEY;
            ks2_q    <= ks1_q;
            kprev_q  <= ks2_q;
        end
    end

    // sprite rows span [y-H/2, y+H/2); the top edge is clamped rather than wrapped
    logic [9:0]  spr_lo;
    logic [10:0] spr_hi;
    logic        spr_en, y_in;
    assign spr_lo = (y_q >= HALF_H) ? (y_q - HALF_H) : 10'd0;
    assign spr_hi = {1'b0, y_q} + {1'b0, HALF_H};
    assign spr_en = (state_q == ST_FALL) && !(judged_q && jhit_q);
    assign y_in   = (next_y >= spr_lo) && ({1'b0, next_y} < spr_hi);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [10:0] X0 = 11'(i * LANE_W);
        localparam logic [10:0] X1 = 11'((i + 1) * LANE_W);
        assign sprite_pattern[i] = spr_en && cur_q[i] && y_in
                                   && ({1'b0, next_x} >= X0) && ({1'b0, next_x} < X1);
    end

    assign y_pos     = y_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign note_done = done_q;
    assign score     = score_q;
    assign combo     = combo_q;

endmodule

// File: tb/tb_note_lanes.sv
// Scoreboard bench for note_lanes: expected pulse events are queued when patterns
// are pushed and compared as hit/miss/note_done pulses appear.
module tb_note_lanes;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key = 4'b1111;
    logic [3:0]  pin = '0;
    logic        pv = 1'b0;
    logic        ready;
    logic [9:0]  nx = '0, ny = '0;
    logic [3:0]  sprite;
    logic [9:0]  y;
    logic        hit, miss, done;
    logic [15:0] score;
    logic [7:0]  combo;

    int errs = 0;
    int checks = 0;
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    note_lanes #(.LANES(4), .TICK_DIV(4), .FIFO_DEPTH(4)) dut (
        .CLOCK_25       (clk),
        .reset          (rst_n),
        .KEY            (key),
        .pattern_in     (pin),
        .pattern_valid  (pv),
        .pattern_ready  (ready),
        .next_x         (nx),
        .next_y         (ny),
        .sprite_pattern (sprite),
        .y_pos          (y),
        .hit            (hit),
        .miss           (miss),
        .note_done      (done),
        .score          (score),
        .combo          (combo)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [26:0] ev(bit h, bit m, bit d, int s, int c);
        return {h, m, d, 16'(s), 8'(c)};
    endfunction

    always @(negedge clk) begin
        if (hit || miss || done) begin
            if (exp_q.size() == 0)
                chk("unexpected_event", {5'd0, hit, miss, done, score, combo}, 32'd0);
            else
                chk("event", {5'd0, hit, miss, done, score, combo}, {5'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_y(input int target);
        int n = 0;
        while (y !== 10'(target) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("timeout_y", {22'd0, y}, target);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("timeout_done", {31'd0, done}, 1);
    endtask

    task automatic spr(input string tag, input int x, input int yy, input logic [3:0] exp);
        nx = 10'(x);
        ny = 10'(yy);
        #1;
        chk(tag, {28'd0, sprite}, {28'd0, exp});
    endtask

    logic [3:0] fill_pats [5] = '{4'b0011, 4'b1000, 4'b0100, 4'b0000, 4'b1111};

    initial begin
        // reset state
        #3;
        spr("rst_sprite", 10, 0, 4'b0000);
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_y", {22'd0, y}, 0);
        chk("rst_score", {16'd0, score}, 0);
        chk("rst_combo", {24'd0, combo}, 0);
        chk("rst_pulses", {29'd0, hit, miss, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // note 1: 0101, correct chord held from y=430
        @(negedge clk);
        pin = 4'b0101; pv = 1'b1;
        exp_q.push_back(ev(1, 0, 0, 1, 1));
        exp_q.push_back(ev(0, 0, 1, 1, 1));
        @(negedge clk);
        pv = 1'b0;

        wait_y(5);
        spr("clamp_lo", 10, 0, 4'b0001);
        spr("lane2_on", 330, 5, 4'b0100);
        spr("lane1_off", 170, 5, 4'b0000);
        spr("y_hi_excl", 10, 21, 4'b0000);
        spr("y_hi_in", 10, 20, 4'b0001);

        // fill the FIFO while note 1 is falling; the 5th push must be dropped
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) chk("ready_full", {31'd0, ready}, 0);
            pin = fill_pats[k]; pv = 1'b1;
        end
        @(negedge clk);
        pv = 1'b0;
        chk("drop_full", {31'd0, ready}, 0);
        exp_q.push_back(ev(0, 1, 0, 1, 0));
        exp_q.push_back(ev(0, 0, 1, 1, 0));
        exp_q.push_back(ev(0, 1, 1, 1, 0));
        exp_q.push_back(ev(0, 1, 1, 1, 0));
        exp_q.push_back(ev(0, 0, 1, 1, 0));

        wait_y(430);
        key = 4'b1010;
        spr("pre_hit", 10, 430, 4'b0001);
        wait_y(435);
        spr("vanish0", 10, 435, 4'b0000);
        spr("vanish2", 330, 435, 4'b0000);
        chk("score_hit", {16'd0, score}, 1);
        chk("combo_hit", {24'd0, combo}, 1);
        wait_done();
        key = 4'b1111;

        // note 2: 0011, wrong chord (lane 0 only) at y=440
        wait_y(440);
        key = 4'b1110;
        repeat (8) @(negedge clk);
        key = 4'b1111;
        chk("combo_miss", {24'd0, combo}, 0);
        spr("miss_still_drawn", 10, y, 4'b0001);
        wait_done();

        // note 3: 1000, no key, miss at exit
        wait_y(480);
        chk("y_reach_exit", {22'd0, y}, 480);
        wait_done();
        chk("y_after_exit", {22'd0, y}, 0);

        // note 4: 0100, presses just outside the window
        wait_y(427);
        key = 4'b1011;
        repeat (6) @(negedge clk);
        key = 4'b1111;
        wait_y(471);
        key = 4'b1011;
        repeat (6) @(negedge clk);
        key = 4'b1111;
        wait_done();

        // note 5: rest
        wait_y(100);
        spr("rest_blank", 10, 100, 4'b0000);
        wait_done();

        repeat (2200) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_y", {22'd0, y}, 0);
        chk("score_final", {16'd0, score}, 1);

        // reset mid-fall aborts the note silently
        @(negedge clk);
        pin = 4'b0010; pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        wait_y(450);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        spr("rst_mid_sprite", 170, 450, 4'b0000);
        chk("rst_mid_y", {22'd0, y}, 0);
        chk("rst_mid_ready", {31'd0, ready}, 1);
        chk("rst_mid_score", {16'd0, score}, 0);
        chk("rst_mid_pulses", {29'd0, hit, miss, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2500) @(negedge clk);
        chk("post_rst_y", {22'd0, y}, 0);
        chk("post_rst_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
